x_uart_rx_cfg: RTL and testbench
================================

// Module: x_uart_rx_cfg
// PURPOSE
//   Parametrised UART receiver. Successor to the fixed 8N1 x_uart_rx.
//   - Configurable data width, parity and stop bits.
//   - Glitch-rejecting start detection.
//   - Parity, framing and overrun error reporting.
//   - Valid/ready output holding register, so a downstream consumer can stall.
//   Sits between the board RX pin and the delay-line command/capture logic.
// PARAMETERS
//   CLK_HZ     100_000_000  system clock frequency in Hz
//   BAUD       115_200      line rate; CPB = CLK_HZ/BAUD (integer divide, CPB >= 8)
//   DATA_BITS  8            data bits per frame, 5..9, LSB first
//   PARITY     0            0 = none, 1 = odd, 2 = even
//   STOP_BITS  1            1 or 2
// PORTS
//   i_clk         in   1          system clock
//   i_rst         in   1          synchronous reset, active-high
//   i_rx          in   1          asynchronous serial line, idle high
//   i_ready       in   1          consumer accepts o_data when o_valid & i_ready
//   o_valid       out  1          holding register full
//   o_data        out  DATA_BITS  received word
//   o_parity_err  out  1          parity mismatch on held word; qualified by o_valid
//   o_frame_err   out  1          any stop bit sampled low on held word; qualified by o_valid
//   o_overrun     out  1          1-cycle pulse: a completed frame was dropped
// BEHAVIOUR
//   Reset state
//     - All outputs 0, FSM in IDLE, counters 0.
//     - Both synchroniser flops reset to 1 (line idle).
//   Input synchroniser
//     - i_rx passes through a 2-FF synchroniser; all FSM decisions use the synced value.
//   FSM states and transitions
//     - IDLE: synced line low -> START, baud counter cleared.
//     - START: at count CPB/2 - 1, sample the line.
//         - Low: -> DATA, counter reloads.
//         - High: glitch, -> IDLE; nothing reported.
//     - DATA: sample every CPB cycles (mid-bit).
//         - Shift in LSB first; after DATA_BITS samples -> PARITY if PARITY != 0, else -> STOP.
//     - PARITY: sample the parity bit.
//         - Even: XOR of data bits and parity bit must be 0. Odd: must be 1.
//     - STOP: sample STOP_BITS stop bits; any low sample sets the frame error.
//         - After the last stop sample: deliver the frame (see below).
//         - Line high -> IDLE. Line low -> BREAK.
//     - BREAK: wait for the synced line to go high, then -> IDLE.
//         - No start detection while in BREAK.
//   Delivery (cycle after the last stop sample)
//     - Holding register empty, or i_ready=1 that same cycle:
//         load o_data and both error flags, o_valid=1.
//     - Otherwise: new frame is discarded, held word is unchanged, o_overrun=1 for 1 cycle.
//   Handshake
//     - o_valid clears on the cycle after o_valid & i_ready, unless a delivery loads that same cycle.
//     - o_data and error flags stay stable while o_valid=1 and i_ready=0.
//     - o_data is undefined while o_valid=0.
//   Frames with errors are still delivered; the consumer decides whether to discard them.
//   Latency: 2 sync cycles + frame time to mid-point of last stop bit + 1 cycle.
//   Reset mid-frame: the partial frame is lost; the FSM re-arms in IDLE immediately.
// STRUCTURE
//   x_uart_pkg
//     - parity_t enum (NONE, ODD, EVEN).
//     - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK).
//     - function cpb(clk_hz, baud).
//   x_uart_rx_baud sub-module
//     - Counter of width $clog2(CPB).
//     - Inputs: clear, half-bit select. Output: 1-cycle sample strobe.
//   Top level holds the synchroniser, FSM, shift register, parity accumulator and output register.
// TESTING  (CLK_HZ=8_000_000, BAUD=1_000_000 -> CPB=8)
//   8N1, i_ready=1, send 0xA5
//     -> single o_valid pulse, o_data=0xA5, both errors 0, o_overrun 0.
//   Glitch: i_rx low for 3 cycles, then high
//     -> no o_valid; FSM back in IDLE; a following 0x3C is received correctly.
//   PARITY=2, send 0x03 with parity bit 1 (wrong)
//     -> o_data=0x03, o_parity_err=1. Repeat with parity bit 0 -> o_parity_err=0.
//   STOP_BITS=2, second stop bit low
//     -> o_frame_err=1.
//     Then hold the line low for 20 bit times -> no further frames.
//     Release the line, send 0x55 -> 0x55 received, no errors.
//   i_ready=0, send 0x11 then 0x22
//     -> o_data holds 0x11; o_overrun pulses once at 0x22 delivery.
//     Raise i_ready -> o_valid drops the next cycle.
//     Complete a frame in the same cycle as i_ready=1 -> new word loaded, no overrun.
//   Assert i_rst after 3 data bits of a frame
//     -> all outputs 0; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/x_uart_pkg.sv
// Shared types and helpers for the configurable UART receiver family.
package x_uart_pkg;

    // Parity mode, encoded to match the integer PARITY parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    // Receiver FSM states with fixed encodings so waveforms stay readable.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Clocks per bit; integer divide, callers keep the result >= 8.
    function automatic int cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/x_uart_rx_baud.sv
// Bit-period timer: emits a one-cycle strobe after a half or full bit period.
module x_uart_rx_baud #(
    parameter int CPB = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic half,
    output logic strobe
);

    localparam int               CNT_W     = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);

    logic [CNT_W-1:0] count;

    assign strobe = (count == (half ? HALF_LAST : FULL_LAST));

    // Free-running count that restarts on clear or on every strobe.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (strobe) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/x_uart_rx_cfg.sv
// Parametrised UART receiver: glitch-rejecting start detection, parity,
// framing and overrun reporting, and a valid/ready holding register.
module x_uart_rx_cfg
    import x_uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int         CPB       = cpb(CLK_HZ, BAUD);
    localparam parity_t    PAR_MODE  = parity_t'(PARITY);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    rx_state_t            state;
    rx_state_t            state_next;
    logic                 baud_clear;
    logic                 baud_half;
    logic                 baud_strobe;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_err;
    logic                 frame_err;
    logic                 deliver;

    // Two-flop synchroniser for the asynchronous RX pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: both flops reset to the idle line level so leaving reset never looks like a start bit.
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_sync take the previous rx_meta, giving two real stages.
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // Timer is held cleared while waiting for a start edge, so START counts from zero.
    assign baud_clear = (state == ST_IDLE) || (state == ST_BREAK);
    assign baud_half  = (state == ST_START);

    x_uart_rx_baud #(
        .CPB(CPB)
    ) u_baud (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (baud_clear),
        .half  (baud_half),
        .strobe(baud_strobe)
    );

    // Next-state logic for the frame FSM.
    always_comb begin
        // NOTE: hold-current default keeps every path assigned, so no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:   if (!rx_sync) state_next = ST_START;
            ST_START:  if (baud_strobe) state_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (baud_strobe && (bit_cnt == LAST_DATA))
                           state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (baud_strobe) state_next = ST_STOP;
            ST_STOP:   if (baud_strobe && (bit_cnt == LAST_STOP))
                           state_next = rx_sync ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_sync) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Bit counter, shift register, parity accumulator and per-frame error capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            deliver   <= 1'b0;
        end else begin
            deliver <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        bit_cnt   <= '0;
                        par_acc   <= 1'b0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (baud_strobe) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        par_acc   <= par_acc ^ rx_sync;
                        bit_cnt   <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    // Even parity wants a total XOR of 0, odd wants 1.
                    if (baud_strobe) par_err <= par_acc ^ rx_sync ^ (PAR_MODE == PAR_ODD);
                end
                ST_STOP: begin
                    if (baud_strobe) begin
                        if (!rx_sync) frame_err <= 1'b1;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            deliver <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding register: load when empty or being drained this cycle, else flag an overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (deliver) begin
                if (!o_valid || i_ready) begin
                    o_valid      <= 1'b1;
                    o_data       <= shift_reg;
                    o_parity_err <= par_err;
                    o_frame_err  <= frame_err;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_x_uart_rx_cfg.sv
// Bench for x_uart_rx_cfg: an 8N1 instance and an 8E2 instance, each with a
// scoreboard queue filled at stimulus time and drained by a handshake monitor.
`timescale 1ns/1ps
module tb_x_uart_rx_cfg;

    localparam int CLK_HZ   = 8_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int N_RAND   = 8;
    // Edge (counted from the frame's first edge) at which an 8N1 frame is delivered:
    // 2 sync + 1 detect + half bit to the start sample, nine more bits, then one cycle.
    localparam int DEL_EDGE = CPB / 2 + 4 + CPB * 9;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic       valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] data_a;
    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic       valid_b, perr_b, ferr_b, ovr_b;
    logic [7:0] data_b;

    always #5 clk = ~clk;

    x_uart_rx_cfg #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .i_ready(ready_a),
        .o_valid(valid_a), .o_data(data_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_overrun(ovr_a)
    );

    x_uart_rx_cfg #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .i_ready(ready_b),
        .o_valid(valid_b), .o_data(data_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_overrun(ovr_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   hold_full [2];
    int   exp_ovr [2];
    int   obs_ovr [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else           rx_b = v;
    endtask

    function automatic logic ready_now(input int inst);
        return (inst == 0) ? ready_a : ready_b;
    endfunction

    // Reference model plus line driver. Instance 0 is 8N1, instance 1 is 8E2.
    // pulse=1 means i_ready is raised for exactly the delivery cycle.
    task automatic send_frame(input int inst, input logic [7:0] data, input logic pbit,
                              input logic stop_low, input logic pulse);
        logic bits[$];
        exp_t e;
        logic rdy_del;
        logic rdy_after;
        e.data    = data;
        e.perr    = (inst == 1) && ((($countones(data) + int'(pbit)) % 2) != 0);
        e.ferr    = stop_low;
        rdy_after = ready_now(inst);
        rdy_del   = rdy_after | pulse;
        if (!hold_full[inst] || rdy_del) begin
            if (inst == 0) q_a.push_back(e);
            else           q_b.push_back(e);
            hold_full[inst] = !rdy_after;
        end else begin
            exp_ovr[inst]++;
        end
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (inst == 1) begin
            bits.push_back(pbit);
            bits.push_back(1'b1);
        end
        bits.push_back(!stop_low);
        @(posedge clk);
        foreach (bits[i]) begin
            #1 drive(inst, bits[i]);
            repeat (CPB) @(posedge clk);
        end
    endtask

    // Monitor for instance A: compare every accepted word with the scoreboard.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && valid_a && ready_a) begin
            check("a_word_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_data", data_a, e.data);
                check("a_parity_err", perr_a, e.perr);
                check("a_frame_err", ferr_a, e.ferr);
            end
        end
        if (!rst && ovr_a) obs_ovr[0]++;
    end

    // Monitor for instance B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && valid_b && ready_b) begin
            check("b_word_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_data", data_b, e.data);
                check("b_parity_err", perr_b, e.perr);
                check("b_frame_err", ferr_b, e.ferr);
            end
        end
        if (!rst && ovr_b) obs_ovr[1]++;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_valid"}, valid_a, 0);
        check({tag, "_a_data"}, data_a, 0);
        check({tag, "_a_perr"}, perr_a, 0);
        check({tag, "_a_ferr"}, ferr_a, 0);
        check({tag, "_a_ovr"}, ovr_a, 0);
        check({tag, "_b_valid"}, valid_b, 0);
        check({tag, "_b_data"}, data_b, 0);
        check({tag, "_b_perr"}, perr_b, 0);
        check({tag, "_b_ferr"}, ferr_b, 0);
        check({tag, "_b_ovr"}, ovr_b, 0);
    endtask

    initial begin : stim
        logic [7:0] d;
        hold_full[0] = 1'b0;
        hold_full[1] = 1'b0;
        exp_ovr[0] = 0;
        exp_ovr[1] = 0;
        obs_ovr[0] = 0;
        obs_ovr[1] = 0;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // 8N1 basic frame
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);

        // Glitch shorter than half a bit must be ignored
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("glitch_no_valid", valid_a, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);

        // Even parity: wrong then correct parity bit
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(1, 8'h03, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);

        // Second stop bit low, then a long break, then a clean frame
        d = 8'($urandom);
        send_frame(1, d, ^d, 1'b1, 1'b0);
        repeat (20 * CPB) @(posedge clk);
        #1 rx_b = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_frame(1, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);

        // Stalled consumer: second frame overruns
        @(posedge clk);
        #1 ready_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_ovr_count", obs_ovr[0], exp_ovr[0]);
        check("stall_valid", valid_a, 1);
        check("stall_held_data", data_a, (q_a.size() != 0) ? 32'(q_a[0].data) : 32'hDEAD);
        @(posedge clk);
        #1 ready_a = 1'b1;
        hold_full[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drain_valid_drops", valid_a, 0);
        @(posedge clk);
        #1 ready_a = 1'b0;

        // Delivery in the same cycle as the handshake: load, no overrun
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);
        fork
            send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (DEL_EDGE - 1) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("same_cycle_ovr_count", obs_ovr[0], exp_ovr[0]);
        check("same_cycle_valid", valid_a, 1);
        check("same_cycle_data", data_a, (q_a.size() != 0) ? 32'(q_a[0].data) : 32'hDEAD);
        @(posedge clk);
        #1 ready_a = 1'b1;
        hold_full[0] = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized traffic on both instances in parallel
        fork
            begin : rand_a
                logic [7:0] ra;
                for (int k = 0; k < N_RAND; k++) begin
                    ra = 8'($urandom);
                    repeat ($urandom_range(0, 12)) @(posedge clk);
                    send_frame(0, ra, 1'b0, 1'b0, 1'b0);
                end
            end
            begin : rand_b
                logic [7:0] rb;
                logic       pb;
                for (int k = 0; k < N_RAND; k++) begin
                    rb = 8'($urandom);
                    pb = (^rb) ^ ($urandom_range(0, 3) == 0);
                    repeat ($urandom_range(0, 12)) @(posedge clk);
                    send_frame(1, rb, pb, 1'b0, 1'b0);
                end
            end
        join
        repeat (CPB) @(posedge clk);

        // Reset three data bits into a frame
        check("pre_reset_q_a_empty", q_a.size(), 0);
        @(posedge clk);
        #1 rx_a = 1'b0;
        d = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_a = d[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rst = 1'b1;
        rx_a = 1'b1;
        hold_full[0] = 1'b0;
        hold_full[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midframe");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        send_frame(1, 8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (2 * CPB) @(posedge clk);

        // Every expected word seen, overrun counts agree
        @(negedge clk);
        check("final_q_a_empty", q_a.size(), 0);
        check("final_q_b_empty", q_b.size(), 0);
        check("final_ovr_a", obs_ovr[0], exp_ovr[0]);
        check("final_ovr_b", obs_ovr[1], exp_ovr[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
